// File: rtl/clock_reset_sequencer_if.sv
// Purpose : bundles the sequencer's DCM-facing and channel-facing signals into one port.
// Latency : none (wiring only).
// Backpressure: none; all signals are level or single-cycle strobes with no handshake.
//
// Signals:
//   dcm_locked      DCM LOCKED, asynchronous to system_clock
//   channel_divide  per-channel divide value, channel i at [i*DIV_WIDTH +: DIV_WIDTH]
//   dcm_reset       DCM RST
//   channel_reset   per-channel synchronous reset, active-high
//   channel_enable  per-channel single-cycle clock enable
//   clocks_ready    high only while the sequence is complete (RUN)
//   retry_count     saturating count of lock timeouts
//   lock_lost_count saturating count of lock losses after release
// master = the sequencer, slave = the clocking block / downstream logic.
interface clock_reset_sequencer_if #(
    parameter int NUM_CHANNELS = 2,
    parameter int DIV_WIDTH    = 8
);
    logic                              dcm_locked;
    logic [NUM_CHANNELS*DIV_WIDTH-1:0] channel_divide;
    logic                              dcm_reset;
    logic [NUM_CHANNELS-1:0]           channel_reset;
    logic [NUM_CHANNELS-1:0]           channel_enable;
    logic                              clocks_ready;
    logic [7:0]                        retry_count;
    logic [7:0]                        lock_lost_count;

    modport master (
        input  dcm_locked,
        input  channel_divide,
        output dcm_reset,
        output channel_reset,
        output channel_enable,
        output clocks_ready,
        output retry_count,
        output lock_lost_count
    );

    modport slave (
        output dcm_locked,
        output channel_divide,
        input  dcm_reset,
        input  channel_reset,
        input  channel_enable,
        input  clocks_ready,
        input  retry_count,
        input  lock_lost_count
    );
endinterface

// File: rtl/clock_reset_sequencer.sv
// Purpose : DCM reset/lock sequencer with staggered per-channel reset release and clock-enable dividers.
// Latency : all outputs registered; lock seen 2 cycles after dcm_locked rises, RELEASE after LOCK_FILTER more.
// Backpressure: none; the sequencer free-runs and retries on lock timeout.
//
// Ports:
//   system_clock  buffered system clock, all logic on the rising edge
//   reset         synchronous, active-high; returns every output to its reset value next edge
//   bus           clock_reset_sequencer_if.master (dcm_locked/channel_divide in, resets/enables/status out)
//
// Optional feature: define CLKSEQ_LOCK_MONITOR_EN to restart the sequence (and count the
// event in lock_lost_count) whenever lock drops during RELEASE or RUN. Without it, lock is
// ignored once RELEASE is entered and lock_lost_count is tied to zero.
module clock_reset_sequencer #(
    parameter int DCM_RESET_CYCLES = 4,
    parameter int LOCK_FILTER      = 16,
    parameter int LOCK_TIMEOUT     = 65535,
    parameter int NUM_CHANNELS     = 2,
    parameter int RELEASE_STAGGER  = 4,
    parameter int DIV_WIDTH        = 8
) (
    input  logic                     system_clock,
    input  logic                     reset,
    clock_reset_sequencer_if.master  bus
);

    // RELEASE lasts until the cycle after the last channel has cleared.
    localparam int REL_LAST_I = (NUM_CHANNELS - 1) * RELEASE_STAGGER + 1;
    localparam int MAX_A      = (DCM_RESET_CYCLES > LOCK_TIMEOUT) ? DCM_RESET_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX    = (MAX_A > REL_LAST_I + 1) ? MAX_A : REL_LAST_I + 1;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int FILT_W     = $clog2(LOCK_FILTER + 1);

    localparam logic [CNT_W-1:0]     DCM_LAST     = CNT_W'(DCM_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]     RELEASE_LAST = CNT_W'(REL_LAST_I);
    localparam logic [FILT_W-1:0]    FILT_LAST    = FILT_W'(LOCK_FILTER - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE      = DIV_WIDTH'(1);

    typedef enum logic [1:0] {
        DCM_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        state_cnt;
    logic [FILT_W-1:0]       filt_cnt;

    logic                    lock_meta;
    logic                    lock_sync;
    logic                    lock_drop;

    logic                    dcm_rst;
    logic                    ready;
    logic [NUM_CHANNELS-1:0] chan_rst;
    logic [NUM_CHANNELS-1:0] chan_en;
    logic [7:0]              retries;
    logic [7:0]              lock_losses;

    logic [NUM_CHANNELS-1:0][DIV_WIDTH-1:0] div_cnt;
    logic [NUM_CHANNELS-1:0][DIV_WIDTH-1:0] div_hold;
    logic [NUM_CHANNELS-1:0][DIV_WIDTH-1:0] div_eff;

    // ------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous DCM lock.
    // ------------------------------------------------------------------
    always_ff @(posedge system_clock) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= bus.dcm_locked;
            lock_sync <= lock_meta;
        end
    end

`ifdef CLKSEQ_LOCK_MONITOR_EN
    // Lock lost after release: restart the whole sequence on the next edge.
    assign lock_drop = ((state == RELEASE) || (state == RUN)) && !lock_sync;

    always_ff @(posedge system_clock) begin
        if (reset) begin
            lock_losses <= 8'd0;
        end else if (lock_drop && (lock_losses != 8'hFF)) begin
            lock_losses <= lock_losses + 8'd1;
        end
    end
`else
    assign lock_drop   = 1'b0;
    assign lock_losses = 8'd0;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM. Outputs are written alongside each transition so they
    // always describe the state being entered, not the one being left.
    // ------------------------------------------------------------------
    always_ff @(posedge system_clock) begin
        if (reset) begin
            state     <= DCM_RST;
            state_cnt <= '0;
            filt_cnt  <= '0;
            dcm_rst   <= 1'b1;
            chan_rst  <= '1;
            ready     <= 1'b0;
            retries   <= 8'd0;
        end else begin
            case (state)
                DCM_RST: begin
                    if (state_cnt == DCM_LAST) begin
                        state     <= WAIT_LOCK;
                        state_cnt <= '0;
                        filt_cnt  <= '0;
                        dcm_rst   <= 1'b0;
                    end else begin
                        state_cnt <= state_cnt + 1'b1;
                    end
                end

                WAIT_LOCK: begin
                    // Lock is tested first so it wins a tie with the timeout.
                    if (lock_sync && (filt_cnt == FILT_LAST)) begin
                        state     <= RELEASE;
                        state_cnt <= '0;
                        filt_cnt  <= '0;
                    end else if (state_cnt == TIMEOUT_LAST) begin
                        state     <= DCM_RST;
                        state_cnt <= '0;
                        filt_cnt  <= '0;
                        dcm_rst   <= 1'b1;
                        if (retries != 8'hFF) begin
                            retries <= retries + 8'd1;
                        end
                    end else begin
                        state_cnt <= state_cnt + 1'b1;
                        filt_cnt  <= lock_sync ? (filt_cnt + 1'b1) : '0;
                    end
                end

                RELEASE: begin
                    if (lock_drop) begin
                        state     <= DCM_RST;
                        state_cnt <= '0;
                        dcm_rst   <= 1'b1;
                        chan_rst  <= '1;
                        ready     <= 1'b0;
                    end else begin
                        // Channel i leaves reset the cycle after the stagger count hits i*RELEASE_STAGGER.
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            if (state_cnt == CNT_W'(i * RELEASE_STAGGER)) begin
                                chan_rst[i] <= 1'b0;
                            end
                        end
                        if (state_cnt == RELEASE_LAST) begin
                            state     <= RUN;
                            state_cnt <= '0;
                            ready     <= 1'b1;
                        end else begin
                            state_cnt <= state_cnt + 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (lock_drop) begin
                        state     <= DCM_RST;
                        state_cnt <= '0;
                        dcm_rst   <= 1'b1;
                        chan_rst  <= '1;
                        ready     <= 1'b0;
                    end
                end

                default: begin
                    state     <= DCM_RST;
                    state_cnt <= '0;
                    filt_cnt  <= '0;
                    dcm_rst   <= 1'b1;
                    chan_rst  <= '1;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-channel clock-enable dividers.
    // The divide value is taken live at the first cycle of each period
    // (counter at 0) and held for the rest of it, so a mid-period change
    // only takes effect once the current period has completed.
    // ------------------------------------------------------------------
    always_comb begin
        div_eff = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            div_eff[i] = (div_cnt[i] == '0) ? bus.channel_divide[i*DIV_WIDTH +: DIV_WIDTH]
                                            : div_hold[i];
        end
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            div_cnt  <= '0;
            div_hold <= '0;
            chan_en  <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                // lock_drop reasserts channel_reset on this same edge, so the
                // enable is suppressed together with it rather than a cycle later.
                if (chan_rst[i] || lock_drop) begin
                    div_cnt[i] <= '0;
                    chan_en[i] <= 1'b0;
                end else begin
                    if (div_cnt[i] == '0) begin
                        div_hold[i] <= div_eff[i];
                    end
                    // Divide of 0 or 1 degenerates to a permanently-high enable.
                    if ((div_eff[i] <= DIV_ONE) || (div_cnt[i] == div_eff[i] - DIV_ONE)) begin
                        div_cnt[i] <= '0;
                        chan_en[i] <= 1'b1;
                    end else begin
                        div_cnt[i] <= div_cnt[i] + DIV_ONE;
                        chan_en[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.dcm_reset       = dcm_rst;
    assign bus.channel_reset   = chan_rst;
    assign bus.channel_enable  = chan_en;
    assign bus.clocks_ready    = ready;
    assign bus.retry_count     = retries;
    assign bus.lock_lost_count = lock_losses;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Purpose : self-checking bench for clock_reset_sequencer with a timeline reference model.
// Latency : expected outputs for cycle c are queued once the inputs up to c-1 are known.
// Backpressure: none; a monitor pops one expectation per cycle at the falling edge.
module tb_clock_reset_sequencer;

    localparam int NCH  = 2;
    localparam int DW   = 8;
    localparam int DRC  = 4;
    localparam int LF   = 8;
    localparam int LT   = 100;
    localparam int RS   = 4;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    clock_reset_sequencer_if #(.NUM_CHANNELS(NCH), .DIV_WIDTH(DW)) bus();

    clock_reset_sequencer #(
        .DCM_RESET_CYCLES(DRC),
        .LOCK_FILTER     (LF),
        .LOCK_TIMEOUT    (LT),
        .NUM_CHANNELS    (NCH),
        .RELEASE_STAGGER (RS),
        .DIV_WIDTH       (DW)
    ) dut (
        .system_clock(clk),
        .reset       (rst),
        .bus         (bus)
    );

    typedef struct packed {
        logic           dcm;
        logic [NCH-1:0] crst;
        logic [NCH-1:0] en;
        logic           rdy;
        logic [7:0]     rc;
        logic [7:0]     lc;
    } obs_t;

    obs_t exp_q[$];
    int   cyc_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Input history, indexed by cycle (inputs driven during that cycle).
    bit                    rst_h [NCYC];
    bit                    lk_h  [NCYC];
    logic [NCH*DW-1:0]     dv_h  [NCYC];

    // Reference model: the sequence is described by when the current attempt
    // began (a_t) and when RELEASE was entered (rel_t, -1 if not yet).
    int a_t, rel_t, retries, losses;
    int pulse_at [NCH];

    function automatic bit ls(input int k);
        return (k >= 2) ? lk_h[k-2] : 1'b0;
    endfunction

    function automatic int per(input int c, input int i);
        logic [NCH*DW-1:0] v;
        logic [DW-1:0]     d;
        v = dv_h[c];
        d = v[i*DW +: DW];
        return (d <= 1) ? 1 : int'(d);
    endfunction

    task automatic model_step(input int c);
        obs_t e;
        int   w, f;
        bit   ok;
        if (rst_h[c-1]) begin
            a_t = c; rel_t = -1; retries = 0; losses = 0;
        end else if (rel_t >= 0) begin
`ifdef CLKSEQ_LOCK_MONITOR_EN
            if (!ls(c-1)) begin
                a_t = c; rel_t = -1;
                if (losses < 255) losses++;
            end
`endif
        end else begin
            w  = a_t + DRC;
            ok = (c - LF >= w);
            for (int k = c - LF; k < c; k++) if (!ls(k)) ok = 1'b0;
            if (ok) rel_t = c;
            else if (c == w + LT) begin
                a_t = c;
                if (retries < 255) retries++;
            end
        end
        e.rc = 8'(retries);
        e.lc = 8'(losses);
        if (rel_t < 0) begin
            e.dcm  = (c < a_t + DRC);
            e.crst = '1;
            e.en   = '0;
            e.rdy  = 1'b0;
        end else begin
            e.dcm  = 1'b0;
            e.rdy  = (c >= rel_t + (NCH-1)*RS + 2);
            e.crst = '0;
            e.en   = '0;
            for (int i = 0; i < NCH; i++) begin
                f = rel_t + i*RS + 1;
                e.crst[i] = (c < f);
                if (c == f) pulse_at[i] = c + per(c, i);
                else if (c > f && c == pulse_at[i]) begin
                    e.en[i]     = 1'b1;
                    pulse_at[i] = c + per(c, i);
                end
            end
        end
        exp_q.push_back(e);
        cyc_q.push_back(c);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    // Monitor: one expectation per cycle, compared at the falling edge.
    initial begin : monitor
        obs_t e, act;
        int   c;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                act.dcm  = bus.dcm_reset;
                act.crst = bus.channel_reset;
                act.en   = bus.channel_enable;
                act.rdy  = bus.clocks_ready;
                act.rc   = bus.retry_count;
                act.lc   = bus.lock_lost_count;
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL outputs cycle=%0d got dcm=%b crst=%b en=%b rdy=%b retry=%0d lost=%0d expected dcm=%b crst=%b en=%b rdy=%b retry=%0d lost=%0d",
                             c, act.dcm, act.crst, act.en, act.rdy, act.rc, act.lc,
                             e.dcm, e.crst, e.en, e.rdy, e.rc, e.lc);
                end
            end
        end
    end

    initial begin : driver
        bit                r, l, lk_cur;
        int                lk_left, ch;
        logic [NCH*DW-1:0] dv;
        rst = 1'b1;
        bus.dcm_locked     = 1'b0;
        dv                 = {8'd1, 8'd4};
        bus.channel_divide = dv;
        lk_cur = 1'b0; lk_left = 0;
        a_t = 0; rel_t = -1; retries = 0; losses = 0;
        for (int i = 0; i < NCH; i++) pulse_at[i] = 0;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            r = 1'b0; l = 1'b0;
            if (c < 3) r = 1'b1;
            else if (c < 120) begin
                l = 1'b1;
                if (c == 62) dv[DW-1:0] = 8'd2;            // mid-period change on channel 0
            end else if (c < 200) begin
                l = 1'b1;
                if ($urandom_range(0, 5) == 0) begin
                    ch = int'($urandom_range(0, NCH-1));
                    dv[ch*DW +: DW] = DW'($urandom_range(0, 6));
                end
            end else if (c < 203) l = 1'b0;                  // short lock loss in RUN
            else if (c < 260) l = 1'b1;
            else if (c < 262) r = 1'b1;
            else if (c < 600) l = 1'b0;                      // never locks: repeated timeouts
            else if (c < 602) r = 1'b1;
            else if (c < 900) l = (((c - 602) % 10) < 5);    // 5-high/5-low chatter
            else if (c == 900) r = 1'b1;
            else if (c < 1000) begin
                l = 1'b1;
                r = (c == 915);                              // reset during RELEASE
            end else begin
                if (lk_left == 0) begin
                    lk_cur  = !lk_cur;
                    lk_left = lk_cur ? int'($urandom_range(1, 60))
                                     : (($urandom_range(0, 3) == 0) ? int'($urandom_range(95, 140))
                                                                    : int'($urandom_range(1, 12)));
                end
                lk_left--;
                l = lk_cur;
                r = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 7) == 0) begin
                    ch = int'($urandom_range(0, NCH-1));
                    dv[ch*DW +: DW] = DW'($urandom_range(0, 6));
                end
            end
            rst                = r;
            bus.dcm_locked     = l;
            bus.channel_divide = dv;
            rst_h[c] = r;
            lk_h[c]  = l;
            dv_h[c]  = dv;
            if (c >= 1) model_step(c);

            // Directed points taken straight from the sequence timing (reset released at cycle 3).
            if (c == 6)   check_int("dcm_reset_last_high", int'(bus.dcm_reset), 1);
            if (c == 7)   check_int("dcm_reset_released", int'(bus.dcm_reset), 0);
            if (c == 16)  check_int("ch0_released_first", int'(bus.channel_reset), 2);
            if (c == 20)  check_int("ready_before_run", int'(bus.clocks_ready), 0);
            if (c == 21)  check_int("ready_in_run", int'(bus.clocks_ready), 1);
            if (c == 21)  check_int("ch1_enable_const", int'(bus.channel_enable[1]), 1);
            if (c == 63)  check_int("ch0_old_period_gap", int'(bus.channel_enable[0]), 0);
            if (c == 64)  check_int("ch0_old_period_end", int'(bus.channel_enable[0]), 1);
            if (c == 65)  check_int("ch0_new_period_gap", int'(bus.channel_enable[0]), 0);
            if (c == 66)  check_int("ch0_new_period_pulse", int'(bus.channel_enable[0]), 1);
            if (c == 590) check_int("retry_after_3_timeouts", int'(bus.retry_count), 3);
            if (c == 899) check_int("chatter_keeps_reset", int'(bus.channel_reset), 3);
            if (c == 917) check_int("reset_in_release_dcm", int'(bus.dcm_reset), 1);
        end

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
        end
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_reset_sequencer.md
# clock_reset_sequencer

Parametrised clock-management sequencer. It sits between the DCM/clock-buffer block and the video/game logic. It generates the DCM reset pulse, qualifies and filters DCM lock, retries on lock timeout, and releases per-channel resets in a staggered order. It also provides per-channel programmable clock-enable dividers, so that downstream domains share the single buffered system clock.

## Interface
- `DCM_RESET_CYCLES`, 4, cycles `dcm_reset` is held high per attempt (≥1)
- `LOCK_FILTER`, 16, consecutive synchronised lock-high cycles required (≥1)
- `LOCK_TIMEOUT`, 65535, cycles allowed in WAIT_LOCK before retry (> LOCK_FILTER)
- `NUM_CHANNELS`, 2, number of reset/enable channels (≥1)
- `RELEASE_STAGGER`, 4, cycles between successive channel reset releases (≥1)
- `DIV_WIDTH`, 8, width of each channel divide value
- `system_clock`  in  1  buffered system clock; all logic rising-edge
- `reset`  in  1  synchronous, active-high
- `dcm_locked`  in  1  DCM LOCKED, asynchronous; 2-flop synchronised internally (`lock_sync`)
- `channel_divide`  in  NUM_CHANNELS*DIV_WIDTH  divide value per channel, channel i at bits [i*DIV_WIDTH +: DIV_WIDTH]
- `dcm_reset`  out  1  DCM RST
- `channel_reset`  out  NUM_CHANNELS  per-channel synchronous reset, active-high
- `channel_enable`  out  NUM_CHANNELS  per-channel single-cycle clock enable
- `clocks_ready`  out  1  high only in RUN
- `retry_count`  out  8  lock-timeout retries, saturating at 255
- `lock_lost_count`  out  8  lock losses after release, saturating at 255

## Operation
- FSM states:
  - DCM_RST: `dcm_reset`=1. Leave for WAIT_LOCK after DCM_RESET_CYCLES cycles.
  - WAIT_LOCK:
    - Filter counter increments while `lock_sync`=1 and clears on 0.
    - Filter count reaching LOCK_FILTER → RELEASE.
    - Timeout counter reaching LOCK_TIMEOUT → DCM_RST, `retry_count`++.
    - Both in the same cycle: lock wins.
  - RELEASE:
    - Stagger counter runs from 0.
    - `channel_reset[i]` clears the cycle after the counter equals i*RELEASE_STAGGER.
    - The cycle after channel NUM_CHANNELS-1 clears → RUN.
  - RUN: `clocks_ready`=1. Terminal, except under lock monitoring (see Configuration).
- All state counters clear on every state entry.
- Outputs are registered. `dcm_reset`, `clocks_ready` and `channel_reset` reflect the current state. Re-entry to DCM_RST sets all `channel_reset` bits in the same cycle that `dcm_reset` rises.
- Divider per channel:
  - While `channel_reset[i]`=1: counter=0, enable=0.
  - Otherwise the counter counts 0..D-1 and `channel_enable[i]`=1 when the counter is D-1 (one pulse every D cycles).
  - D=0 or D=1: enable is constantly 1.
  - D is latched from `channel_divide` at reset release and at each counter wrap. Mid-period changes take effect at the next wrap.
- Saturating counters never wrap. They are cleared only by `reset`.

## Timing
- During `reset` and the first cycle after: state=DCM_RST, `dcm_reset`=1, `channel_reset`=all 1, `channel_enable`=0, `clocks_ready`=0, `retry_count`=0, `lock_lost_count`=0.
- `dcm_reset` is high for exactly DCM_RESET_CYCLES cycles after `reset` falls.
- Lock latency: `dcm_locked` rising at cycle t gives `lock_sync`=1 at t+2. RELEASE is entered at t+2+LOCK_FILTER if the lock stays high.
- `clocks_ready` rises (NUM_CHANNELS-1)*RELEASE_STAGGER+2 cycles after RELEASE entry.
- The first `channel_enable[i]` pulse comes D cycles after `channel_reset[i]` falls.
- `reset` asserted mid-sequence: all outputs return to reset values on the next edge.

## Configuration
- `CLKSEQ_LOCK_MONITOR_EN` defined:
  - In RELEASE or RUN, `lock_sync`=0 → DCM_RST next cycle.
  - `lock_lost_count`++ on each such transition.
  - All channel resets reassert.
- Not defined:
  - Lock is ignored after WAIT_LOCK.
  - RUN is held until `reset`.
  - `lock_lost_count` is tied to 0.

## Test plan
Bench parameters: DCM_RESET_CYCLES=4, LOCK_FILTER=8, LOCK_TIMEOUT=100, NUM_CHANNELS=2, RELEASE_STAGGER=4, divides {4,1}.
- Release `reset`, `dcm_locked` high from cycle 0:
  - `dcm_reset` is high for 4 cycles.
  - `channel_reset[0]` clears before `channel_reset[1]`, 4 cycles apart.
  - `clocks_ready` rises 6 cycles after RELEASE entry.
- `dcm_locked` never high: `dcm_reset` re-pulses every 104 cycles; `retry_count` reads 3 after the third timeout.
- `dcm_locked` toggling with a period of 10 (5 high): never reaches RELEASE; `channel_reset` stays all 1.
- After RUN, `channel_enable[0]` pulses every 4th cycle and `channel_enable[1]` is constantly 1. Change divide[0] to 2 mid-period: the old period completes, then pulses every 2 cycles.
- With the macro, drop `dcm_locked` in RUN: within 3 cycles `clocks_ready`=0, `channel_reset`=11, `dcm_reset`=1, `lock_lost_count`=1. Without the macro: no change.
- Assert `reset` during RELEASE: all outputs return to reset values next edge; counters=0.
